// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back handshake bundle for regfile_scoreboard.
// master = decode/write-back side, slave = scoreboard.
interface regfile_scoreboard_if #(
  parameter int unsigned ADDR_WID   = 4,
  parameter int unsigned NUM_OF_REG = 8
);
  logic                  flush;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [ADDR_WID-1:0]   issue_srcA;
  logic [ADDR_WID-1:0]   issue_srcB;
  logic [ADDR_WID-1:0]   issue_destE;
  logic [ADDR_WID-1:0]   issue_destM;
  logic                  wb_valid;
  logic [ADDR_WID-1:0]   wb_destE;
  logic [ADDR_WID-1:0]   wb_destM;
  logic                  stall;
  logic [NUM_OF_REG-1:0] busy_mask;
  logic                  idle;
  logic                  err_underflow;

  modport master (
    output flush, issue_valid, issue_srcA, issue_srcB, issue_destE, issue_destM,
    output wb_valid, wb_destE, wb_destM,
    input  issue_ready, stall, busy_mask, idle, err_underflow
  );

  modport slave (
    input  flush, issue_valid, issue_srcA, issue_srcB, issue_destE, issue_destM,
    input  wb_valid, wb_destE, wb_destM,
    output issue_ready, stall, busy_mask, idle, err_underflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: counts in-flight writes per architectural register
// and stalls decode issue while a source still has an older write pending.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle retire resolve the
// last pending write (matching register-file write-then-read timing).
module regfile_scoreboard #(
  parameter int unsigned ADDR_WID   = 4,
  parameter int unsigned NUM_OF_REG = 8,
  parameter int unsigned RNONE      = 15,
  parameter int unsigned CNT_WID    = 2
) (
  input logic                  CLK,
  input logic                  RST_N,
  regfile_scoreboard_if.slave  sbIf
);

  localparam logic [CNT_WID-1:0]  CNT_MAX   = '1;
  localparam logic [ADDR_WID-1:0] NONE_ADDR = ADDR_WID'(RNONE);

  logic [CNT_WID-1:0]    cnt     [NUM_OF_REG];
  logic [CNT_WID-1:0]    cntNext [NUM_OF_REG];
  logic [NUM_OF_REG-1:0] retiring;
  logic [NUM_OF_REG-1:0] issuing;
  logic [NUM_OF_REG-1:0] pendReg;
  logic [NUM_OF_REG-1:0] satReg;
  logic [NUM_OF_REG-1:0] busyNext;
  logic [NUM_OF_REG-1:0] busyQ;
  logic                  pendA, pendB, sat;
  logic                  stallC, readyC, accept;
  logic                  idleQ, errQ, errNext;

  // Per-register retire/pending/saturation view and the source hazard terms
  always_comb begin
    retiring = '0;
    pendReg  = '0;
    satReg   = '0;
    pendA    = 1'b0;
    pendB    = 1'b0;
    sat      = 1'b0;
    for (int r = 0; r < NUM_OF_REG; r++) begin
      if (ADDR_WID'(r) != NONE_ADDR) begin
        retiring[r] = sbIf.wb_valid &&
                      (sbIf.wb_destE == ADDR_WID'(r) || sbIf.wb_destM == ADDR_WID'(r));
`ifdef SCOREBOARD_BYPASS_EN
        pendReg[r]  = (cnt[r] != '0) && !((cnt[r] == CNT_WID'(1)) && retiring[r]);
        satReg[r]   = (cnt[r] == CNT_MAX) && !retiring[r];
`else
        pendReg[r]  = (cnt[r] != '0);
        satReg[r]   = (cnt[r] == CNT_MAX);
`endif
        if (pendReg[r] && sbIf.issue_srcA == ADDR_WID'(r)) pendA = 1'b1;
        if (pendReg[r] && sbIf.issue_srcB == ADDR_WID'(r)) pendB = 1'b1;
        if (satReg[r] && (sbIf.issue_destE == ADDR_WID'(r) ||
                          sbIf.issue_destM == ADDR_WID'(r))) sat = 1'b1;
      end
    end
  end

  assign stallC = sbIf.issue_valid && (pendA || pendB);
  assign readyC = !stallC && !sat && !sbIf.flush;
  assign accept = sbIf.issue_valid && readyC;

  // Next-state counters: flush clears, otherwise net issue-minus-retire per register
  always_comb begin
    issuing  = '0;
    busyNext = '0;
    errNext  = errQ;
    for (int r = 0; r < NUM_OF_REG; r++) begin
      cntNext[r] = cnt[r];
      if (ADDR_WID'(r) != NONE_ADDR) begin
        issuing[r] = accept &&
                     (sbIf.issue_destE == ADDR_WID'(r) || sbIf.issue_destM == ADDR_WID'(r));
      end
      if (sbIf.flush) begin
        cntNext[r] = '0;
      end else if (issuing[r] && !retiring[r]) begin
        cntNext[r] = cnt[r] + CNT_WID'(1);
      end else if (retiring[r] && !issuing[r]) begin
        if (cnt[r] == '0) errNext = 1'b1;
        else              cntNext[r] = cnt[r] - CNT_WID'(1);
      end
      busyNext[r] = (cntNext[r] != '0);
    end
  end

  // Counter, debug mask and sticky error registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < NUM_OF_REG; r++) cnt[r] <= '0;
      busyQ <= '0;
      idleQ <= 1'b1;
      errQ  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_OF_REG; r++) cnt[r] <= cntNext[r];
      busyQ <= busyNext;
      idleQ <= (busyNext == '0);
      errQ  <= errNext;
    end
  end

  assign sbIf.stall         = stallC;
  assign sbIf.issue_ready   = readyC;
  assign sbIf.busy_mask     = busyQ;
  assign sbIf.idle          = idleQ;
  assign sbIf.err_underflow = errQ;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a per-register count model.
module tb_regfile_scoreboard;

  localparam int unsigned ADDR_WID   = 4;
  localparam int unsigned NUM_OF_REG = 8;
  localparam int unsigned RNONE      = 15;
  localparam int unsigned CNT_WID    = 2;
  localparam int          CNT_MAX    = (1 << CNT_WID) - 1;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  regfile_scoreboard_if #(.ADDR_WID(ADDR_WID), .NUM_OF_REG(NUM_OF_REG)) sbIf ();

  regfile_scoreboard #(
    .ADDR_WID(ADDR_WID), .NUM_OF_REG(NUM_OF_REG), .RNONE(RNONE), .CNT_WID(CNT_WID)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .sbIf(sbIf)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: in-flight write count per register ----------------
  int mCnt [NUM_OF_REG];
  bit mErr = 1'b0;

  function automatic bit tracked(input int a);
    return (a >= 0) && (a < int'(NUM_OF_REG)) && (a != int'(RNONE));
  endfunction

  function automatic bit retiringNow(input int a);
    return sbIf.wb_valid && tracked(a) &&
           (int'(sbIf.wb_destE) == a || int'(sbIf.wb_destM) == a);
  endfunction

  function automatic bit pending(input int a);
    if (!tracked(a) || mCnt[a] == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    if (mCnt[a] == 1 && retiringNow(a)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit full(input int a);
    if (!tracked(a) || mCnt[a] != CNT_MAX) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    if (retiringNow(a)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit mStall();
    return sbIf.issue_valid &&
           (pending(int'(sbIf.issue_srcA)) || pending(int'(sbIf.issue_srcB)));
  endfunction

  function automatic bit mReady();
    return !mStall() && !full(int'(sbIf.issue_destE)) &&
           !full(int'(sbIf.issue_destM)) && !sbIf.flush;
  endfunction

  function automatic int mMask();
    int m = 0;
    for (int r = 0; r < int'(NUM_OF_REG); r++) if (mCnt[r] != 0) m |= (1 << r);
    return m;
  endfunction

  initial for (int r = 0; r < int'(NUM_OF_REG); r++) mCnt[r] = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < int'(NUM_OF_REG); r++) mCnt[r] = 0;
      mErr = 1'b0;
    end else if (sbIf.flush) begin
      for (int r = 0; r < int'(NUM_OF_REG); r++) mCnt[r] = 0;
    end else begin
      bit acc;
      acc = sbIf.issue_valid && mReady();
      for (int r = 0; r < int'(NUM_OF_REG); r++) begin
        bit inc, dec;
        inc = acc && tracked(r) &&
              (int'(sbIf.issue_destE) == r || int'(sbIf.issue_destM) == r);
        dec = retiringNow(r);
        if (inc && !dec) mCnt[r]++;
        else if (dec && !inc) begin
          if (mCnt[r] == 0) mErr = 1'b1;
          else              mCnt[r]--;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge CLK) begin
    check("stall",       32'(sbIf.stall),         32'(mStall()));
    check("issue_ready", 32'(sbIf.issue_ready),   32'(mReady()));
    check("busy_mask",   32'(sbIf.busy_mask),     32'(mMask()));
    check("idle",        32'(sbIf.idle),          32'(mMask() == 0));
    check("err",         32'(sbIf.err_underflow), 32'(mErr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idleIn();
    sbIf.flush       = 1'b0;
    sbIf.issue_valid = 1'b0;
    sbIf.issue_srcA  = 4'hF;
    sbIf.issue_srcB  = 4'hF;
    sbIf.issue_destE = 4'hF;
    sbIf.issue_destM = 4'hF;
    sbIf.wb_valid    = 1'b0;
    sbIf.wb_destE    = 4'hF;
    sbIf.wb_destM    = 4'hF;
  endtask

  task automatic issue(input logic [3:0] sa, input logic [3:0] sb,
                       input logic [3:0] de, input logic [3:0] dm);
    sbIf.issue_valid = 1'b1;
    sbIf.issue_srcA  = sa;
    sbIf.issue_srcB  = sb;
    sbIf.issue_destE = de;
    sbIf.issue_destM = dm;
  endtask

  task automatic retire(input logic [3:0] de, input logic [3:0] dm);
    sbIf.wb_valid = 1'b1;
    sbIf.wb_destE = de;
    sbIf.wb_destM = dm;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idleIn();
  endtask

  // ---------------- directed sequence with literal expectations ----------------
  initial begin
    idleIn();
    #1 RST_N = 1'b0;
    #1;
    check("rst_busy",  32'(sbIf.busy_mask),     32'h00);
    check("rst_idle",  32'(sbIf.idle),          32'h1);
    check("rst_stall", 32'(sbIf.stall),         32'h0);
    check("rst_ready", 32'(sbIf.issue_ready),   32'h1);
    check("rst_err",   32'(sbIf.err_underflow), 32'h0);
    @(negedge CLK) RST_N = 1'b1;
    tick();

    // RAW hazard on r3
    issue(4'hF, 4'hF, 4'd3, 4'hF);
    #1 check("raw_issue_ready", 32'(sbIf.issue_ready), 32'h1);
    tick();
    issue(4'd3, 4'hF, 4'hF, 4'hF);
    #1;
    check("raw_stall", 32'(sbIf.stall),       32'h1);
    check("raw_ready", 32'(sbIf.issue_ready), 32'h0);
    check("raw_busy",  32'(sbIf.busy_mask),   32'h08);
    tick();
    issue(4'd3, 4'hF, 4'hF, 4'hF);
    retire(4'd3, 4'hF);
    #1;
`ifdef SCOREBOARD_BYPASS_EN
    check("raw_retire_cycle_stall", 32'(sbIf.stall), 32'h0);
`else
    check("raw_retire_cycle_stall", 32'(sbIf.stall), 32'h1);
`endif
    tick();
    issue(4'd3, 4'hF, 4'hF, 4'hF);
    #1;
    check("raw_after_stall", 32'(sbIf.stall),       32'h0);
    check("raw_after_ready", 32'(sbIf.issue_ready), 32'h1);
    check("raw_after_busy",  32'(sbIf.busy_mask),   32'h00);
    tick();

    // Dual destination
    issue(4'hF, 4'hF, 4'd4, 4'd4);
    tick();
    check("dual_same", 32'(sbIf.busy_mask), 32'h10);
    issue(4'hF, 4'hF, 4'd4, 4'd6);
    tick();
    check("dual_diff", 32'(sbIf.busy_mask), 32'h50);

    // Simultaneous issue and retire on r1
    issue(4'hF, 4'hF, 4'd1, 4'hF);
    tick();
    check("r1_set", 32'(sbIf.busy_mask), 32'h52);
    issue(4'hF, 4'hF, 4'd1, 4'hF);
    retire(4'd1, 4'hF);
    tick();
    check("r1_net0", 32'(sbIf.busy_mask), 32'h52);
    retire(4'd1, 4'hF);
    tick();
    check("r1_clear", 32'(sbIf.busy_mask), 32'h50);
    retire(4'd4, 4'd6);
    tick();
    check("r4r6_retire", 32'(sbIf.busy_mask), 32'h10);
    retire(4'd4, 4'd4);
    tick();
    check("r4_retire_busy", 32'(sbIf.busy_mask), 32'h00);
    check("r4_retire_idle", 32'(sbIf.idle),      32'h1);

    // Saturation of r2
    for (int i = 0; i < 3; i++) begin
      issue(4'hF, 4'hF, 4'd2, 4'hF);
      tick();
    end
    check("sat_busy", 32'(sbIf.busy_mask), 32'h04);
    issue(4'hF, 4'hF, 4'd2, 4'hF);
    #1;
    check("sat_ready", 32'(sbIf.issue_ready), 32'h0);
    check("sat_stall", 32'(sbIf.stall),       32'h0);
    issue(4'd9, 4'd12, 4'hF, 4'hF);
    #1 check("untracked_src_ready", 32'(sbIf.issue_ready), 32'h1);
    tick();

    // Underflow on r7
    retire(4'd7, 4'hF);
    tick();
    check("uf_err",  32'(sbIf.err_underflow), 32'h1);
    check("uf_busy", 32'(sbIf.busy_mask),     32'h04);

    // Flush with issue and retire present
    issue(4'hF, 4'hF, 4'd5, 4'hF);
    retire(4'd2, 4'hF);
    sbIf.flush = 1'b1;
    #1 check("flush_ready", 32'(sbIf.issue_ready), 32'h0);
    tick();
    check("flush_busy", 32'(sbIf.busy_mask),     32'h00);
    check("flush_idle", 32'(sbIf.idle),          32'h1);
    check("flush_err",  32'(sbIf.err_underflow), 32'h1);

    // RNONE never stalls or counts
    issue(4'hF, 4'hF, 4'hF, 4'hF);
    #1;
    check("rnone_ready", 32'(sbIf.issue_ready), 32'h1);
    check("rnone_stall", 32'(sbIf.stall),       32'h0);
    tick();
    check("rnone_idle", 32'(sbIf.idle), 32'h1);

    // Asynchronous reset mid-run with r2:1, r5:2
    issue(4'hF, 4'hF, 4'd2, 4'd5);
    tick();
    issue(4'hF, 4'hF, 4'd5, 4'hF);
    tick();
    check("pre_rst_busy", 32'(sbIf.busy_mask), 32'h24);
    issue(4'd5, 4'hF, 4'hF, 4'hF);
    #1 check("pre_rst_stall", 32'(sbIf.stall), 32'h1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_busy",  32'(sbIf.busy_mask),     32'h00);
    check("mid_rst_idle",  32'(sbIf.idle),          32'h1);
    check("mid_rst_stall", 32'(sbIf.stall),         32'h0);
    check("mid_rst_err",   32'(sbIf.err_underflow), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    idleIn();
    tick();
    tick();
    check("post_rst_idle", 32'(sbIf.idle), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Tracks in-flight writes to each architectural register of the dual-write register file.
- Stalls decode-stage issue while a source register has an outstanding write from an older instruction.
- Sits between the decode stage (issue side) and the write-back stage (retire side); the register file itself is unchanged.
- Produces the stall/ready handshake and a per-register busy mask for debug.

Parameters:
- ADDR_WID, 4, register address width (matches `ADDR_WID in head.v)
- NUM_OF_REG, 8, number of tracked registers; addresses 0..NUM_OF_REG-1
- RNONE, 4'hF, "no register" code; never tracked, never pending
- CNT_WID, 2, per-register in-flight counter width; max in-flight per register = 2^CNT_WID-1

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all tracking (pipeline flush)
- issue_valid  input  1  decode presents an instruction
- issue_ready  output  1  scoreboard accepts the instruction this cycle
- issue_srcA  input  ADDR_WID  source register A
- issue_srcB  input  ADDR_WID  source register B
- issue_destE  input  ADDR_WID  E-destination of issuing instruction
- issue_destM  input  ADDR_WID  M-destination of issuing instruction
- wb_valid  input  1  write-back retires one instruction
- wb_destE  input  ADDR_WID  retiring E-destination
- wb_destM  input  ADDR_WID  retiring M-destination
- stall  output  1  source hazard present
- busy_mask  output  NUM_OF_REG  bit i = counter[i] != 0 (registered)
- idle  output  1  no writes in flight (registered)
- err_underflow  output  1  sticky: retire to a register with count 0

Behaviour:
- Address handling:
  - A register address is tracked iff it is < NUM_OF_REG and != RNONE.
  - Untracked addresses never stall, increment or decrement.
- Reset (RST_N=0, asynchronous):
  - All counters = 0; err_underflow = 0; busy_mask = 0; idle = 1.
  - Combinational outputs follow from these: stall = 0, issue_ready = 1.
- Hazard and handshake (combinational from registered counters and current inputs):
  - pendA = tracked(srcA) && cnt[srcA] != 0; pendB likewise for srcB.
  - stall = issue_valid && (pendA || pendB).
  - sat = any tracked destination has cnt = max.
  - issue_ready = !stall && !sat && !flush.
  - Accept = issue_valid && issue_ready.
- Counter update on each rising CLK, in priority order:
  1. flush: all counters := 0. Issue and retire in the same cycle are dropped; err_underflow is kept.
  2. Otherwise, per register r:
     - inc_r = Accept && (destE==r || destM==r); counts once if destE==destM.
     - dec_r = wb_valid && (wb_destE==r || wb_destM==r); counts once if both equal r.
     - cnt[r] += inc_r - dec_r. Simultaneous inc and dec on the same register gives net 0.
     - dec_r with cnt[r]=0 and no inc_r: cnt stays 0 and err_underflow := 1 (sticky until reset).
- Registered outputs:
  - busy_mask and idle are derived from the next-state counters.
  - They are therefore valid one cycle after the update.
- Latency:
  - An accepted issue makes its destinations pending from the next cycle.
  - A retire clears pending from the next cycle (no same-cycle bypass by default).
- Structure: issue_ready is combinational from inputs; no combinational path from wb_* to issue_ready unless the optional feature is enabled.

Optional Feature:
- Macro: SCOREBOARD_BYPASS_EN.
- Defined: pendA/pendB treat a register as not pending when cnt=1 and the same register is retired this cycle (wb_valid with matching wb_destE/wb_destM). The issue proceeds in the retire cycle, which matches register-file write-then-read timing. The saturation check likewise subtracts a same-cycle retire.
- Undefined: behaviour exactly as in Behaviour; one bubble after each retire that resolves a hazard.

Test Plan:
- Reset mid-run: counts {r2:1, r5:2}, drop RST_N asynchronously between edges -> busy_mask=0, idle=1, stall=0, err_underflow=0 immediately.
- Basic RAW hazard:
  - Issue destE=3 (accepted); next cycle issue srcA=3 -> stall=1, issue_ready=0.
  - wb_valid, wb_destE=3 -> stall=0 the following cycle.
  - With SCOREBOARD_BYPASS_EN: stall=0 in the retire cycle itself.
- Dual destination:
  - destE=4, destM=4 accepted -> cnt[4]=1.
  - destE=4, destM=6 -> cnt[4]=2, cnt[6]=1, busy_mask=8'h50.
- Simultaneous issue and retire on r1 with cnt[1]=1 -> cnt[1] stays 1, busy_mask bit1 stays 1.
- Saturation and underflow:
  - Issue destE=2 three times with CNT_WID=2 -> fourth issue with destE=2 gets issue_ready=0.
  - Retire wb_destE=7 with cnt[7]=0 -> err_underflow=1, cnt[7]=0.
- Flush and RNONE:
  - flush with issue_valid=1 and wb_valid=1 -> all counters 0 next cycle, idle=1, no accept.
  - srcA=destE=RNONE -> never stalls, never counts.
